// File: rtl/me_search_loader.sv
`default_nettype none
//============================================================================
// Module : me_search_loader
// Brief  : Streams a motion-estimation search window into the 3-column and
//          2-column search banks, then kicks the ME engine.
// Rev    : 1.0  initial release
//============================================================================
module me_search_loader #(
    parameter int unsigned DEPTH3 = 256,
    parameter int unsigned DEPTH2 = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    input  logic [8:0]   num_rows,
    input  logic         abort,
    input  logic         in_valid,
    input  logic [135:0] in_data,
    output logic         in_ready,
    output logic         WE_S,
    output logic         WE_S2,
    output logic [7:0]   WADDR_S,
    output logic [135:0] WDATA_S,
    output logic         busy,
    output logic         load_done,
    output logic         me_start
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_KICK = 2'd3;

    logic [1:0]   r_state;
    logic [8:0]   r_cnt;
    logic [8:0]   r_num_rows;
    logic         r_we_s;
    logic         r_we_s2;
    logic [7:0]   r_waddr;
    logic [135:0] r_wdata;
    logic         r_load_done;
    logic         r_me_start;

    logic w_accept;
    logic w_last;
    logic w_rows_legal;
    logic w_bank2;

    assign in_ready     = (r_state == c_LOAD) && !abort;
    assign w_accept     = in_valid && in_ready;
    assign w_last       = (r_cnt == r_num_rows - 9'd1);
    assign w_rows_legal = (32'(num_rows) <= DEPTH3);
    assign w_bank2      = (32'(r_cnt) < DEPTH2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_num_rows  <= '0;
            r_we_s      <= 1'b0;
            r_we_s2     <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_load_done <= 1'b0;
            r_me_start  <= 1'b0;
        end else begin
            r_we_s      <= 1'b0;
            r_we_s2     <= 1'b0;
            r_load_done <= 1'b0;
            r_me_start  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (load_start) begin
                        if (num_rows == 9'd0) begin
                            r_state     <= c_DONE;
                            r_load_done <= 1'b1;
                        end else if (w_rows_legal) begin
                            r_num_rows <= num_rows;
                            r_cnt      <= '0;
                            r_state    <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (w_accept) begin
                        // Write lands one cycle after acceptance; the
                        // final write coincides with load_done.
                        r_we_s  <= 1'b1;
                        r_we_s2 <= w_bank2;
                        r_waddr <= r_cnt[7:0];
                        r_wdata <= in_data;
                        r_cnt   <= r_cnt + 9'd1;
                        if (w_last) begin
                            r_state     <= c_DONE;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    r_state    <= c_KICK;
                    r_me_start <= 1'b1;
                end
                c_KICK: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign WE_S      = r_we_s;
    assign WE_S2     = r_we_s2;
    assign WADDR_S   = r_waddr;
    assign WDATA_S   = r_wdata;
    assign busy      = (r_state != c_IDLE);
    assign load_done = r_load_done;
    assign me_start  = r_me_start;

endmodule
`default_nettype wire

// File: tb/tb_me_search_loader.sv
`default_nettype none
//============================================================================
// Module : tb_me_search_loader
// Brief  : Table-driven, scoreboarded bench for me_search_loader.
// Rev    : 1.0  initial release
//============================================================================
module tb_me_search_loader;

    localparam int c_DEPTH2 = 128;

    typedef struct {
        int n;
        int stall;
        int abort_at;
        int ls_mid;
        bit ls_abort;
        bit exp_busy;
        int exp_writes;
        bit exp_done;
    } vec_t;

    typedef struct {
        logic [7:0]   addr;
        logic [135:0] data;
        logic         we2;
    } wr_t;

    logic         clk;
    logic         rst;
    logic         load_start;
    logic [8:0]   num_rows;
    logic         abort;
    logic         in_valid;
    logic [135:0] in_data;
    logic         in_ready;
    logic         WE_S;
    logic         WE_S2;
    logic [7:0]   WADDR_S;
    logic [135:0] WDATA_S;
    logic         busy;
    logic         load_done;
    logic         me_start;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  n_we = 0;
    int  n_done = 0;
    int  n_me = 0;
    int  last_we_cyc = -1;
    int  done_cyc = -1;
    int  me_cyc = -1;
    wr_t sb[$];
    wr_t mon_e;
    vec_t tbl[9];

    me_search_loader #(.DEPTH3(256), .DEPTH2(128)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .num_rows(num_rows),
        .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .WE_S(WE_S), .WE_S2(WE_S2), .WADDR_S(WADDR_S),
        .WDATA_S(WDATA_S), .busy(busy), .load_done(load_done),
        .me_start(me_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every observed write must match the next queued row.
    always @(negedge clk) begin
        if (WE_S) begin
            n_we++;
            last_we_cyc = cyc;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got write at addr %0d expected no write", WADDR_S);
            end else begin
                mon_e = sb.pop_front();
                chk("waddr", 32'(WADDR_S), 32'(mon_e.addr));
                chkw("wdata", WDATA_S, mon_e.data);
                chk("we_s2", 32'(WE_S2), 32'(mon_e.we2));
            end
        end else begin
            chk("we_s2_without_we_s", 32'(WE_S2), 32'd0);
        end
        if (load_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (me_start) begin
            n_me++;
            me_cyc = cyc;
        end
    end

    task automatic run_load(input vec_t v);
        int sent, guard, we0, done0, me0, ls_cyc;
        logic [159:0] r;
        bit aborted;
        sent = 0; guard = 0; aborted = 0;
        we0 = n_we; done0 = n_done; me0 = n_me;
        load_start = 1'b1;
        num_rows   = v.n[8:0];
        abort      = v.ls_abort;
        ls_cyc     = cyc;
        @(posedge clk); #1;
        load_start = 1'b0;
        abort      = 1'b0;
        #1;
        chk("busy_after_start", 32'(busy), 32'(v.exp_busy));
        chk("in_ready_after_start", 32'(in_ready), 32'(v.exp_busy && v.n > 0));
        if (v.exp_busy && v.n > 0) begin
            while (sent < v.n && guard < 5000) begin
                guard++;
                r = {$urandom, $urandom, $urandom, $urandom, $urandom};
                in_data = r[135:0];
                if (v.abort_at >= 0 && sent == v.abort_at) begin
                    abort    = 1'b1;
                    in_valid = 1'b1;
                    #1 chk("in_ready_on_abort", 32'(in_ready), 32'd0);
                    @(posedge clk); #1;
                    abort    = 1'b0;
                    in_valid = 1'b0;
                    #1 chk("busy_after_abort", 32'(busy), 32'd0);
                    aborted = 1;
                    break;
                end
                in_valid = ($urandom_range(99) >= v.stall);
                if (v.ls_mid >= 0 && sent == v.ls_mid) begin
                    load_start = 1'b1;
                    num_rows   = 9'd5;
                end
                #1 chk("in_ready_in_load", 32'(in_ready), 32'd1);
                if (in_valid) begin
                    sb.push_back('{addr: sent[7:0], data: in_data, we2: (sent < c_DEPTH2)});
                    sent++;
                end
                @(posedge clk); #1;
                load_start = 1'b0;
            end
            in_valid = 1'b0;
            if (guard >= 5000) begin
                n_cmp++;
                n_err++;
                $display("FAIL load_budget: got %0d rows expected %0d", sent, v.n);
            end
            if (!aborted) begin
                #1 chk("in_ready_after_last", 32'(in_ready), 32'd0);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        chk("write_count", 32'(n_we - we0), 32'(v.exp_writes));
        chk("load_done_count", 32'(n_done - done0), 32'(v.exp_done));
        chk("me_start_count", 32'(n_me - me0), 32'(v.exp_done));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("busy_back_idle", 32'(busy), 32'd0);
        if (v.exp_done) begin
            chk("me_start_after_done", 32'(me_cyc), 32'(done_cyc + 1));
            if (v.n == 0) chk("done_timing_empty", 32'(done_cyc), 32'(ls_cyc + 1));
            else          chk("done_with_last_write", 32'(done_cyc), 32'(last_we_cyc));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we_s"}, 32'(WE_S), 32'd0);
        chk({tag, "_we_s2"}, 32'(WE_S2), 32'd0);
        chk({tag, "_waddr"}, 32'(WADDR_S), 32'd0);
        chkw({tag, "_wdata"}, WDATA_S, 136'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_me_start"}, 32'(me_start), 32'd0);
    endtask

    initial begin
        int done0, me0;
        //            n    stall abort  lsmid lsab busy writes done
        tbl[0] = '{4,   0,  -1, -1, 0, 1, 4,   1};
        tbl[1] = '{256, 50, -1, -1, 0, 1, 256, 1};
        tbl[2] = '{0,   0,  -1, -1, 0, 1, 0,   1};
        tbl[3] = '{300, 0,  -1, -1, 0, 0, 0,   0};
        tbl[4] = '{10,  0,  5,  -1, 0, 1, 5,   0};
        tbl[5] = '{12,  20, -1, 3,  0, 1, 12,  1};
        tbl[6] = '{3,   0,  -1, -1, 1, 1, 3,   1};
        tbl[7] = '{130, 30, -1, -1, 0, 1, 130, 1};
        tbl[8] = '{1,   0,  -1, -1, 0, 1, 1,   1};

        rst = 1'b1; load_start = 1'b0; num_rows = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0;
        #3 chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_load(tbl[i]);

        // Asynchronous reset in the middle of a load.
        load_start = 1'b1; num_rows = 9'd20;
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = {4{32'hA5A5_0000 + k}};
            sb.push_back('{addr: 8'(k), data: {4{32'hA5A5_0000 + k}}, we2: 1'b1});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        sb.delete();
        done0 = n_done; me0 = n_me;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_reset", 32'(n_done - done0), 32'd0);
        chk("no_me_start_after_reset", 32'(n_me - me0), 32'd0);
        run_load(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/me_search_loader.md
ME_SEARCH_LOADER -- requirements
Module: me_search_loader

Interface
REQ-001 SHALL have parameter DEPTH3, default 256, row depth of the 3-column search banks (8-bit write address).
REQ-002 SHALL have parameter DEPTH2, default 128, row depth of the 2-column search banks (7-bit write address).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load_start  input  1  one-cycle request to load a search window.
REQ-007 num_rows  input  9  rows to load, sampled with load_start; legal 0..DEPTH3.
REQ-008 abort  input  1  cancels a load in progress.
REQ-009 in_valid  input  1  source has a row on in_data.
REQ-010 in_data  input  136  one row of 17 pixels, pixel 0 in [135:128].
REQ-011 in_ready  output  1  loader accepts a row this cycle.
REQ-012 WE_S  output  1  write enable, 3-column banks.
REQ-013 WE_S2  output  1  write enable, 2-column banks.
REQ-014 WADDR_S  output  8  bank row address; 2-column banks use [6:0].
REQ-015 WDATA_S  output  136  row write data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 load_done  output  1  one-cycle pulse, window fully written.
REQ-018 me_start  output  1  one-cycle pulse to the ME engine start input.

Function
REQ-019 SHALL implement FSM IDLE, LOAD, DONE, KICK.
REQ-020 IDLE: load_start with 1<=num_rows<=DEPTH3 -> latch num_rows, clear row counter, go LOAD.
REQ-021 IDLE: load_start with num_rows==0 -> go DONE directly, no writes issued.
REQ-022 IDLE: load_start with num_rows>DEPTH3 -> ignored, stay IDLE.
REQ-023 load_start outside IDLE SHALL be ignored.
REQ-024 in_ready SHALL be combinationally high exactly when state==LOAD and abort==0.
REQ-025 A row is accepted on a cycle with in_valid & in_ready; stalls (in_valid low) SHALL hold counter and outputs WE low.
REQ-026 Accepted row at counter value a SHALL produce, on the next cycle (latency 1, registered): WE_S=1, WADDR_S=a[7:0], WDATA_S=in_data.
REQ-027 WE_S2 SHALL be 1 on that cycle iff a<DEPTH2; otherwise 0.
REQ-028 WE_S and WE_S2 SHALL be low on every cycle with no accepted row in the prior cycle; WADDR_S/WDATA_S hold last value.
REQ-029 Counter SHALL increment by 1 per accepted row; addresses SHALL be 0,1,2,... with no wrap (max DEPTH3-1).
REQ-030 Accepting row num_rows-1 SHALL move LOAD -> DONE; in_ready low from next cycle.
REQ-031 DONE SHALL last one cycle with load_done=1, coinciding with the final write cycle; then KICK.
REQ-032 KICK SHALL last one cycle with me_start=1; then IDLE.
REQ-033 abort high in LOAD SHALL go IDLE next cycle, no load_done/me_start; a row with in_valid on the abort cycle is not accepted.
REQ-034 abort outside LOAD SHALL have no effect.
REQ-035 load_start and abort on the same IDLE cycle: load_start wins.

Reset
REQ-036 rst high SHALL immediately force state IDLE, counter 0, WE_S=0, WE_S2=0, WADDR_S=0, WDATA_S=0, load_done=0, me_start=0, busy=0, in_ready=0.
REQ-037 rst asserted mid-LOAD SHALL abandon the load; no pulse of load_done or me_start after release.

Verification
REQ-038 load_start, num_rows=4, in_valid continuously high, data D0..D3 -> WE_S at addrs 0..3 on consecutive cycles, WE_S2=1 each, load_done with addr-3 write, me_start one cycle later.
REQ-039 num_rows=256, in_valid random 50% -> 256 WE_S writes addrs 0..255 in order, WE_S2=1 only for addrs 0..127, zero writes during stalls.
REQ-040 num_rows=0 -> no WE_S, load_done on cycle 2 after load_start, me_start cycle 3; num_rows=300 -> ignored, busy stays 0.
REQ-041 num_rows=10, abort after 5 accepts with in_valid high -> exactly 5 writes (addrs 0..4), no load_done/me_start, busy low next cycle.
REQ-042 rst asserted asynchronously mid-cycle during LOAD -> all outputs 0 before next clk edge; new load_start afterwards restarts at addr 0.
REQ-043 load_start pulsed during LOAD -> ignored; row count and addresses unaffected.
